// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle shift/rotate unit. One operand is captured on a
// start handshake and stepped one bit position per clock. The unit reports the
// last bit shifted or rotated out and pulses done for one cycle at the end.
module shift_seq_unit #(
    parameter int WIDTH = 8,
    // Derived from WIDTH; leave at its default.
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] r,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    // Operation encodings, kept as named constants so the step table reads clearly.
    localparam logic [2:0] MODE_SHL0 = 3'b000;
    localparam logic [2:0] MODE_SHL1 = 3'b001;
    localparam logic [2:0] MODE_SHR0 = 3'b010;
    localparam logic [2:0] MODE_SHR1 = 3'b011;
    localparam logic [2:0] MODE_ASR  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ROL  = 3'b110;
    localparam logic [2:0] MODE_HOLD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // One single-bit step. Result is {bit_out, new_value}; hold and any
    // unknown encoding leave the value untouched and report a zero out-bit.
    function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] v,
                                               input logic [2:0]       m);
        logic [WIDTH:0] res;
        res = {1'b0, v};
        case (m)
            MODE_SHL0: res = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            MODE_SHL1: res = {v[WIDTH-1], v[WIDTH-2:0], 1'b1};
            MODE_SHR0: res = {v[0], 1'b0, v[WIDTH-1:1]};
            MODE_SHR1: res = {v[0], 1'b1, v[WIDTH-1:1]};
            MODE_ASR:  res = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            MODE_ROR:  res = {v[0], v[0], v[WIDTH-1:1]};
            MODE_ROL:  res = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            MODE_HOLD: res = {1'b0, v};
            default:   res = {1'b0, v};
        endcase
        return res;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [AMT_W-1:0] count_r;
    logic [AMT_W-1:0] count_s;
    logic [2:0]       mode_r;
    logic [2:0]       mode_s;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_s;
    logic             sout_r;
    logic             sout_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH:0]   step_s;

    // Single step of the current result under the latched mode.
    always_comb begin
        step_s = step_fn(r_r, mode_r);
    end

    // Next-state and datapath update: accept in IDLE/DONE, step in SHIFT.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        mode_s  = mode_r;
        r_s     = r_r;
        sout_s  = sout_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                    count_s = amt;
                    mode_s  = mode;
                    r_s     = a;
                    sout_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count_r != {AMT_W{1'b0}}) begin
                    r_s     = step_s[WIDTH-1:0];
                    sout_s  = step_s[WIDTH];
                    count_s = count_r - AMT_W'(1);
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                // A request in the completion cycle is taken back-to-back.
                if (start) begin
                    state_s = ST_SHIFT;
                    count_s = amt;
                    mode_s  = mode;
                    r_s     = a;
                    sout_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= {AMT_W{1'b0}};
            mode_r  <= 3'b000;
            r_r     <= {WIDTH{1'b0}};
            sout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            mode_r  <= mode_s;
            r_r     <= r_s;
            sout_r  <= sout_s;
            busy_r  <= (state_s == ST_SHIFT);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign r    = r_r;
    assign sout = sout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit (WIDTH=8): a table of operations with
// hand-derived results, plus hand-written sequences for ignored starts,
// back-to-back requests and reset during an operation.
module tb_shift_seq_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [2:0] mode;
    logic [2:0] amt;
    logic [7:0] r;
    logic       sout;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [2:0] mode;
        logic [2:0] amt;
        logic [7:0] exp_r;
        logic       exp_sout;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic       sout;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    shift_seq_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .mode  (mode),
        .amt   (amt),
        .r     (r),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive a request for one edge, optionally record its expected result,
    // then scramble the inputs to show they are not used after acceptance.
    task automatic start_op(input logic [7:0] va, input logic [2:0] vm,
                            input logic [2:0] vn, input logic [7:0] er,
                            input logic es, input bit push);
        exp_t e;
        a     = va;
        mode  = vm;
        amt   = vn;
        start = 1'b1;
        if (push) begin
            e.r    = er;
            e.sout = es;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        mode  = 3'($urandom);
        amt   = 3'($urandom);
    endtask

    // From a negedge inside SHIFT, count busy cycles until done appears.
    task automatic wait_done(output int busy_n, output bit seen);
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    // Wait for completion and compare against the oldest scoreboard entry.
    task automatic finish_op(input string nm, input int exp_busy);
        int   bn;
        bit   seen;
        exp_t e;
        wait_done(bn, seen);
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_busy_cycles"}, bn, exp_busy);
        chk({nm, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({nm, "_r"}, int'(r), int'(e.r));
            chk({nm, "_sout"}, int'(sout), int'(e.sout));
        end
    endtask

    initial begin
        int dn;
        checks = 0;
        errors = 0;

        //            a      mode    amt   exp_r  exp_sout
        vecs[0]  = '{8'h96, 3'b000, 3'd3, 8'hB0, 1'b0};
        vecs[1]  = '{8'h96, 3'b001, 3'd3, 8'hB7, 1'b0};
        vecs[2]  = '{8'h96, 3'b010, 3'd3, 8'h12, 1'b1};
        vecs[3]  = '{8'h35, 3'b011, 3'd2, 8'hCD, 1'b0};
        vecs[4]  = '{8'h96, 3'b100, 3'd2, 8'hE5, 1'b1};
        vecs[5]  = '{8'h35, 3'b100, 3'd3, 8'h06, 1'b1};
        vecs[6]  = '{8'h96, 3'b101, 3'd5, 8'hB4, 1'b1};
        vecs[7]  = '{8'h96, 3'b110, 3'd4, 8'h69, 1'b1};
        vecs[8]  = '{8'h96, 3'b111, 3'd3, 8'h96, 1'b0};
        vecs[9]  = '{8'h96, 3'b011, 3'd0, 8'h96, 1'b0};
        vecs[10] = '{8'hFF, 3'b000, 3'd7, 8'h80, 1'b1};
        vecs[11] = '{8'h01, 3'b010, 3'd7, 8'h00, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        mode  = 3'b000;
        amt   = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_r", int'(r), 0);
        chk("reset_sout", int'(sout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single operations, each followed by an idle gap.
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].mode, vecs[i].amt,
                     vecs[i].exp_r, vecs[i].exp_sout, 1'b1);
            finish_op($sformatf("vec%0d", i), int'(vecs[i].amt) + 1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_width", i), int'(done), 0);
            chk($sformatf("vec%0d_idle_busy", i), int'(busy), 0);
            @(negedge clk);
        end

        // A start while busy is ignored: one done, original result.
        start_op(8'h96, 3'b101, 3'd5, 8'hB4, 1'b1, 1'b1);
        @(negedge clk);
        a     = 8'h01;
        mode  = 3'b000;
        amt   = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("ignore_busy", 4);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("ignore_busy_extra_done", dn, 0);
        chk("ignore_busy_sb_empty", sb_q.size(), 0);

        // Back-to-back: new request in the DONE cycle.
        start_op(8'h96, 3'b000, 3'd3, 8'hB0, 1'b0, 1'b1);
        finish_op("b2b_first", 4);
        start_op(8'h96, 3'b110, 3'd4, 8'h69, 1'b1, 1'b1);
        chk("b2b_done_width", int'(done), 0);
        chk("b2b_busy_again", int'(busy), 1);
        finish_op("b2b_second", 5);
        @(negedge clk);
        chk("b2b_done_end", int'(done), 0);

        // Reset at E2 of an amt=5 operation: reset values, no done later.
        start_op(8'hA5, 3'b101, 3'd5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_r", int'(r), 0);
        chk("midrst_sout", int'(sout), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst_no_done", dn, 0);

        // Reset coincident with start: request is dropped.
        start_op(8'h3C, 3'b000, 3'd0, 8'h3C, 1'b0, 1'b1);
        finish_op("pre_rst_start", 1);
        a     = 8'hFF;
        mode  = 3'b000;
        amt   = 3'd2;
        start = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_start_r", int'(r), 0);
        chk("rst_start_busy", int'(busy), 0);
        @(negedge clk);
        chk("rst_start_busy_after", int'(busy), 0);
        chk("rst_start_done_after", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Parametrised, multi-cycle shift/rotate unit: the WIDTH-bit generalisation of the team's 4-bit combinational shifter. It takes an operand, a 3-bit mode and a shift amount, then shifts one bit position per clock under a start/busy/done handshake. It also reports the last bit shifted out. It sits between the datapath register file and the result bus, alongside the counter blocks.

## Interface
- WIDTH, default 8: operand/result width; legal values WIDTH >= 2.
- AMT_W, default $clog2(WIDTH): shift-amount width, derived; not overridden.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when the unit is not busy.
- a  input  WIDTH  operand; captured on the accepting edge.
- mode  input  3  operation; captured on the accepting edge.
- amt  input  AMT_W  number of single-bit steps (0..WIDTH-1); captured on the accepting edge.
- r  output  WIDTH  result register.
- sout  output  1  last bit shifted or rotated out.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

## Operation
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: r=0, sout=0, busy=0, done=0; state=IDLE; count=0.
- States:
  - IDLE: waiting.
  - SHIFT: stepping.
  - DONE: one-cycle completion.
- Accepting a request: start=1 in IDLE or DONE, on the edge:
  - r<=a, sout<=0, count<=amt;
  - mode is latched;
  - state<=SHIFT.
- SHIFT, count != 0: perform one step on r, update sout, count<=count-1, stay in SHIFT.
- SHIFT, count == 0: state<=DONE; r and sout hold.
- DONE: lasts exactly one cycle; with no start, next state is IDLE.
- Step per latched mode (r[W-1] is the MSB):
  - 000: shift left, fill 0; sout<=r[W-1].
  - 001: shift left, fill 1; sout<=r[W-1].
  - 010: shift right, fill 0; sout<=r[0].
  - 011: shift right, fill 1; sout<=r[0].
  - 100: arithmetic shift right (MSB replicated); sout<=r[0].
  - 101: rotate right; sout<=r[0].
  - 110: rotate left; sout<=r[W-1].
  - 111: hold; no change to r; sout stays 0; count still decrements.
- Outputs: busy=1 only in SHIFT; done=1 only in DONE. r and sout hold between operations.
- Input changes after acceptance: a, mode and amt changing mid-operation have no effect.

## Timing
- Accepting edge E0 → SHIFT. Steps occur on edges E1..E(amt); edge E(amt+1) enters DONE.
- done is high for exactly the cycle after E(amt+1). r and sout are final and stable in that cycle.
- busy rises after E0 and falls after E(amt+1).
- amt=0: one cycle in SHIFT with no step; done follows E1; r=a, sout=0.
- start while busy=1: ignored; no queuing.
- start in DONE cycle: accepted (back-to-back). The next edge goes to SHIFT, not IDLE. The done pulse is still exactly one cycle.
- Throughput: one operation per amt+2 cycles.
- rst overrides all: rst=1 on any edge, including mid-SHIFT and coincident with start, gives the reset values on that edge; start is dropped.

## Test plan
- WIDTH=8, a=0x96, mode=000, amt=3, start pulse:
  - busy high for 4 cycles;
  - done one cycle after E4;
  - r=0xB0, sout=0.
- a=0x96, mode=100, amt=2 → r=0xE5, sout=1.
- a=0x96, mode=110, amt=4 → r=0x69, sout=1.
- a=0x96, mode=011, amt=0:
  - done after E1;
  - r=0x96, sout=0, busy high for exactly 1 cycle.
- a=0x96, mode=101, amt=5; then start with a=0x01 at E2 while busy:
  - the second request is ignored;
  - r=0xB4, sout=1, done once.
- Back-to-back and reset:
  - start again during DONE: the new operation completes correctly.
  - rst at E2 of an amt=5 operation: next cycle r=0, busy=0, done=0, sout=0; no done pulse follows.
